fetch_queue: RTL

Two-wide instruction fetch stage directly downstream of the instruction cache. Drives the fetch address into the icache each cycle and splits each returned 64-bit line into up to two 32-bit instructions. Tags each instruction with its PC and buffers it in a circular queue. Presents the two oldest entries to dispatch, and flushes and redirects on a branch-recovery request from the back end.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 76 +++++++
 rtl/fetch_queue.sv | 101 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and sizing for the two-wide fetch stage.
// Holds the queue entry layout {pc, inst} used by fetch_queue and fetch_fifo.
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int FQ_DEPTH    = 8;
    localparam int FETCH_WIDTH = 2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-in/2-out circular buffer of fq_entry_t with sync clear.
// Ports: push_cnt/push_data in, pop_cnt in, head_data (head, head+1) and count out.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic [1:0]                   push_cnt,
    input  fq_entry_t [1:0]              push_data,
    input  logic [1:0]                   pop_cnt,
    output fq_entry_t [1:0]              head_data,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fq_entry_t     mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] head_p1;
    logic [PW-1:0] tail_p1;
    logic [1:0]    pop_lim;
    logic [1:0]    eff_pop;

    assign head_p1 = head + PW'(1);
    assign tail_p1 = tail + PW'(1);

    // Pops beyond the current occupancy are clamped so the
    // pointers never run past the tail.
    always_comb begin
        pop_lim = (pop_cnt == 2'd3) ? 2'd2 : pop_cnt;
        eff_pop = 2'd0;
        unique case (1'b1)
            (count == '0): begin
                eff_pop = 2'd0;
            end
            (count == CW'(1)): begin
                eff_pop = (pop_lim != 2'd0) ? 2'd1 : 2'd0;
            end
            (count > CW'(1)): begin
                eff_pop = pop_lim;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            if (push_cnt != 2'd0) begin
                mem[tail] <= push_data[0];
            end
            if (push_cnt == 2'd2) begin
                mem[tail_p1] <= push_data[1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(eff_pop);
            tail  <= tail + PW'(push_cnt);
            count <= count + CW'(push_cnt) - CW'(eff_pop);
        end
    end

    assign head_data[0] = mem[head];
    assign head_data[1] = mem[head_p1];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: drives the icache fetch PC, splits 64-bit lines into two
// instructions, queues them and presents the two oldest to dispatch.
module fetch_queue #(
    parameter int XLEN     = fetch_pkg::XLEN,
    parameter int FQ_DEPTH = fetch_pkg::FQ_DEPTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [63:0]                   Icache_data_in,
    input  logic                          Icache_valid_in,
    output logic [XLEN-1:0]               proc2Icache_addr,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    input  logic [1:0]                    dispatch_take,
    output logic [1:0][31:0]              inst_out,
    output logic [1:0][XLEN-1:0]          pc_out,
    output logic [1:0]                    inst_valid_out,
    output logic [$clog2(FQ_DEPTH):0]     fq_count
);

    import fetch_pkg::*;

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] redirect_base;
    logic [XLEN-1:0] pc_step;
    logic [CW-1:0]   count;
    logic            enq;
    logic [1:0]      push_cnt;
    fq_entry_t [1:0] push_data;
    fq_entry_t [1:0] head_data;
    logic            unused_redirect_lsbs;

    assign redirect_base        = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Space check uses the registered count only; entries leaving
    // this cycle do not make room for the incoming line.
    always_comb begin
        enq = Icache_valid_in && !redirect_valid
            && ((CW'(FQ_DEPTH) - count) >= CW'(2));

        push_cnt          = 2'd0;
        pc_step           = '0;
        push_data[0].pc   = fetch_pc;
        push_data[0].inst = Icache_data_in[31:0];
        push_data[1].pc   = fetch_pc + XLEN'(4);
        push_data[1].inst = Icache_data_in[63:32];

        unique case (1'b1)
            !enq: begin
                push_cnt = 2'd0;
            end
            (enq && !fetch_pc[2]): begin
                push_cnt = 2'd2;
                pc_step  = XLEN'(8);
            end
            // Odd-word PC: only the upper half is useful, and the
            // +4 step lands on the next line boundary.
            (enq && fetch_pc[2]): begin
                push_cnt          = 2'd1;
                pc_step           = XLEN'(4);
                push_data[0].inst = Icache_data_in[63:32];
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_base;
        end else if (enq) begin
            fetch_pc <= fetch_pc + pc_step;
        end
    end

    fetch_fifo #(
        .DEPTH (FQ_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (redirect_valid),
        .push_cnt  (push_cnt),
        .push_data (push_data),
        .pop_cnt   (dispatch_take),
        .head_data (head_data),
        .count     (count)
    );

    assign proc2Icache_addr  = fetch_pc;
    assign fq_count          = count;
    assign inst_valid_out[0] = (count > CW'(0));
    assign inst_valid_out[1] = (count > CW'(1));
    assign inst_out[0]       = head_data[0].inst;
    assign inst_out[1]       = head_data[1].inst;
    assign pc_out[0]         = head_data[0].pc;
    assign pc_out[1]         = head_data[1].pc;

endmodule
